// File: rtl/mcb_port_responder.sv
// mcb_port_responder: memory side of one MCB user port (command FSM, FWFT write/read FIFOs, backing store).
// Define MCB_RESP_MASK_EN to honour wr_mask byte enables; otherwise every write stores the full word.
module mcb_port_responder #(
  parameter int MEM_ADDR_W   = 12,
  parameter int CALIB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_bl,
  input  logic [29:0] cmd_byte_addr,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_mask,
  output logic        wr_full,
  output logic        wr_empty,
  output logic [6:0]  wr_count,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_full,
  output logic        rd_empty,
  output logic [6:0]  rd_count,
  output logic        calib_done
);

  localparam int MEM_WORDS = 32'd1 << MEM_ADDR_W;
  localparam int CAL_W     = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_CALIB = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [CAL_W-1:0]      calib_cnt_r;
  logic [6:0]            rem_r, rem_s;
  logic [MEM_ADDR_W-1:0] addr_r, addr_s;
  logic                  cmd_full_r, calib_done_r;
  logic                  fetch_s;

  logic [31:0] wf_data_r [64];
`ifdef MCB_RESP_MASK_EN
  logic [3:0]  wf_mask_r [64];
`endif
  logic [5:0]  wf_wptr_r, wf_rptr_r;
  logic [6:0]  wf_count_r, wf_count_s;
  logic        wf_full_r, wf_empty_r;
  logic        wf_push_s, wf_pop_s;

  logic [31:0] mem_r [MEM_WORDS];
  logic [31:0] mem_q_r;
  logic        mem_vld_r;

  logic [31:0] rf_data_r [64];
  logic [5:0]  rf_wptr_r, rf_rptr_r, rf_rptr_s;
  logic [6:0]  rf_count_r, rf_count_s, rf_left_s;
  logic        rf_full_r, rf_empty_r;
  logic        rf_push_s, rf_pop_s;
  logic [31:0] rf_head_s, rd_data_r;

  // Byte-lane address bits and upper address bits are ignored by design
  logic unused_s;
  assign unused_s = ^{cmd_byte_addr, wr_mask};

  // Next-state and burst bookkeeping for the command FSM
  always_comb begin
    state_s  = state_r;
    rem_s    = rem_r;
    addr_s   = addr_r;
    wf_pop_s = 1'b0;
    fetch_s  = 1'b0;
    case (state_r)
      ST_CALIB: begin
        if (calib_cnt_r == CAL_W'(CALIB_CYCLES - 1)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CALIB;
        end
      end
      ST_IDLE: begin
        if (cmd_en) begin
          addr_s = cmd_byte_addr[MEM_ADDR_W+1:2];
          rem_s  = {1'b0, cmd_bl} + 7'd1;
          case (cmd_instr)
            3'b000, 3'b010: state_s = ST_WRITE;
            3'b001, 3'b011: state_s = ST_READ;
            default:        state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // Once the whole burst is buffered the FIFO never runs dry mid-burst
        if (wf_count_r >= rem_r) begin
          wf_pop_s = 1'b1;
          addr_s   = addr_r + MEM_ADDR_W'(1'b1);
          rem_s    = rem_r - 7'd1;
          if (rem_r == 7'd1) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_WRITE;
          end
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_READ: begin
        // Count the word still in the memory pipeline so the read FIFO cannot overflow
        if (({1'b0, rf_count_r} + {7'd0, mem_vld_r}) < 8'd64) begin
          fetch_s = 1'b1;
          addr_s  = addr_r + MEM_ADDR_W'(1'b1);
          rem_s   = rem_r - 7'd1;
          if (rem_r == 7'd1) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_READ;
        end
      end
      default: state_s = ST_CALIB;
    endcase
  end

  // FSM state register, calibration counter and command-side flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_CALIB;
      calib_cnt_r  <= {CAL_W{1'b0}};
      rem_r        <= 7'd0;
      addr_r       <= {MEM_ADDR_W{1'b0}};
      cmd_full_r   <= 1'b1;
      calib_done_r <= 1'b0;
      mem_vld_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_CALIB) begin
        calib_cnt_r <= calib_cnt_r + CAL_W'(1'b1);
      end
      rem_r        <= rem_s;
      addr_r       <= addr_s;
      cmd_full_r   <= (state_s != ST_IDLE);
      calib_done_r <= calib_done_r | (state_s != ST_CALIB);
      mem_vld_r    <= fetch_s;
    end
  end

  // FIFO push/pop qualification, next occupancy and next read-FIFO head word
  always_comb begin
    wf_push_s  = wr_en && (!wf_full_r || wf_pop_s);
    wf_count_s = wf_count_r + {6'd0, wf_push_s} - {6'd0, wf_pop_s};
    rf_push_s  = mem_vld_r;
    rf_pop_s   = rd_en && !rf_empty_r;
    rf_count_s = rf_count_r + {6'd0, rf_push_s} - {6'd0, rf_pop_s};
    rf_left_s  = rf_count_r - {6'd0, rf_pop_s};
    rf_rptr_s  = rf_rptr_r + {5'd0, rf_pop_s};
    if (rf_count_s == 7'd0) begin
      rf_head_s = rd_data_r;
    end else if (rf_left_s == 7'd0) begin
      rf_head_s = mem_q_r;
    end else begin
      rf_head_s = rf_data_r[rf_rptr_s];
    end
  end

  // FIFO pointers, occupancy and registered status/data outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wf_wptr_r  <= 6'd0;
      wf_rptr_r  <= 6'd0;
      wf_count_r <= 7'd0;
      wf_full_r  <= 1'b0;
      wf_empty_r <= 1'b1;
      rf_wptr_r  <= 6'd0;
      rf_rptr_r  <= 6'd0;
      rf_count_r <= 7'd0;
      rf_full_r  <= 1'b0;
      rf_empty_r <= 1'b1;
      rd_data_r  <= 32'd0;
    end else begin
      wf_wptr_r  <= wf_wptr_r + {5'd0, wf_push_s};
      wf_rptr_r  <= wf_rptr_r + {5'd0, wf_pop_s};
      wf_count_r <= wf_count_s;
      wf_full_r  <= (wf_count_s == 7'd64);
      wf_empty_r <= (wf_count_s == 7'd0);
      rf_wptr_r  <= rf_wptr_r + {5'd0, rf_push_s};
      rf_rptr_r  <= rf_rptr_s;
      rf_count_r <= rf_count_s;
      rf_full_r  <= (rf_count_s == 7'd64);
      rf_empty_r <= (rf_count_s == 7'd0);
      rd_data_r  <= rf_head_s;
    end
  end

  // FIFO storage arrays, not reset
  always_ff @(posedge clk) begin
    if (wf_push_s) begin
      wf_data_r[wf_wptr_r] <= wr_data;
`ifdef MCB_RESP_MASK_EN
      wf_mask_r[wf_wptr_r] <= wr_mask;
`endif
    end
    if (rf_push_s) begin
      rf_data_r[rf_wptr_r] <= mem_q_r;
    end
  end

  // Backing store: burst writes from the write FIFO, one-cycle-latency fetches
  always_ff @(posedge clk) begin
    if (wf_pop_s) begin
`ifdef MCB_RESP_MASK_EN
      for (int b = 0; b < 4; b++) begin
        if (!wf_mask_r[wf_rptr_r][b]) begin
          mem_r[addr_r][8*b +: 8] <= wf_data_r[wf_rptr_r][8*b +: 8];
        end
      end
`else
      mem_r[addr_r] <= wf_data_r[wf_rptr_r];
`endif
    end
    if (fetch_s) begin
      mem_q_r <= mem_r[addr_r];
    end
  end

  assign cmd_full   = cmd_full_r;
  assign calib_done = calib_done_r;
  assign wr_full    = wf_full_r;
  assign wr_empty   = wf_empty_r;
  assign wr_count   = wf_count_r;
  assign rd_full    = rf_full_r;
  assign rd_empty   = rf_empty_r;
  assign rd_count   = rf_count_r;
  assign rd_data    = rd_data_r;

endmodule
